str_window_former: RTL
======================

Name: str_window_former

Overview:
- Upstream neighbour of the per-string-size bloom engine.
- Converts a packetised byte stream, one byte per beat, into every overlapping STR_SIZE-byte window of each packet.
- Presents each window on a valid/ready interface that matches the engine's data input.
- Keeps saturating statistics counters: windows emitted, short packets, protocol errors. Each counter clears on a strobe.

Parameters:
- BYTE_W, 8, width of one stream byte.
- STR_SIZE, 3, window length in bytes; legal range >= 1.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- data_i  in  BYTE_W  input byte.
- sop_i  in  1  first byte of packet.
- eop_i  in  1  last byte of packet.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- data_o  out  STR_SIZE x BYTE_W  window; element [0] is the oldest byte, element [STR_SIZE-1] is the newest.
- valid_o  out  1  window valid.
- ready_i  in  1  downstream ready.
- windows_cnt_o  out  CNT_W  windows transferred (valid_o && ready_i).
- short_pkt_cnt_o  out  CNT_W  packets that ended before producing any window.
- proto_err_cnt_o  out  CNT_W  protocol violations.
- cnt_clean_stb_i  in  1  synchronous clear of all three counters.

Behaviour:
- Reset (async assert, sync deassert internally):
  - valid_o=0, data_o=0, all counters 0.
  - fill=0, in_pkt=0, window shift register 0.
- Input handshake:
  - ready_o = !valid_o || ready_i (combinational).
  - accept = valid_i && ready_o.
  - No state changes without accept, except the output transfer and the counters.
- On accept, in this priority order:
  - sop_i=1: new packet. Set in_pkt=1 and fill=1. The byte enters the shift register as the newest element.
    - If in_pkt was already 1, this is a missing eop: proto_err +1.
    - If that aborted packet had fill<STR_SIZE, also short_pkt +1.
  - sop_i=0 and in_pkt=1: shift the byte in. fill = min(fill+1, STR_SIZE), saturating.
  - sop_i=0 and in_pkt=0: discard the byte and increment proto_err. No other state changes, even if eop_i=1.
  - eop_i=1 with a valid packet byte (the sop case or the in_pkt case):
    - After the update, in_pkt=0 and fill=0.
    - If the updated fill<STR_SIZE, short_pkt +1.
    - sop_i=eop_i=1 is a one-byte packet; it is short when STR_SIZE>1.
- Window output:
  - Load data_o with the shift-register contents after the update, and set valid_o=1, exactly when all of these hold: accept, the byte was used (not discarded), and the updated fill == STR_SIZE.
  - Latency: 1 cycle from the accept edge of a byte to the valid_o that shows the window ending in that byte.
  - valid_o and data_o hold stable while ready_i=0.
  - valid_o clears after a transfer, unless a new window loads on the same edge.
  - Back-to-back windows run at full rate while ready_i stays high.
  - A packet of N>=STR_SIZE bytes gives exactly N-STR_SIZE+1 windows. Windows never span packets.
- STR_SIZE=1: every byte of a packet is a window; short_pkt never increments.
- Counters:
  - Each increments by at most 1 per cycle per counter.
  - Each saturates at all-ones; no wrap.
  - cnt_clean_stb_i sets all three to 0 and takes priority over a same-cycle increment (that event is not counted).
  - Two events on the same counter in one cycle cannot occur. The sop-abort case counts short_pkt once, for the aborted packet.
- Reset mid-packet: the partial packet is dropped silently, with no counter effects, and any pending window is lost.

Test Plan (STR_SIZE=3, BYTE_W=8):
1. Packet 0x41,0x42,0x43,0x44,0x45 (sop on the first byte, eop on the last), ready_i=1.
   - Expect windows {41,42,43}, {42,43,44}, {43,44,45} on consecutive cycles, first one 1 cycle after byte 0x43 is accepted.
   - windows_cnt_o=3, short_pkt_cnt_o=0.
2. Same packet with ready_i low for 4 cycles after the first window.
   - ready_o=0 during the stall; data_o holds {41,42,43}.
   - After the stall, all 3 windows arrive in order with none lost.
3. Packet of 2 bytes, then a single-byte packet with sop_i=eop_i=1.
   - No valid_o; short_pkt_cnt_o=2, windows_cnt_o=0.
4. Byte with sop_i=0 while idle, then packet 0x01,0x02, then sop on 0x0A,0x0B,0x0C with eop.
   - proto_err_cnt_o=2 (stray byte, missing eop) and short_pkt_cnt_o=1.
   - Exactly one window {0A,0B,0C}.
5. Pulse cnt_clean_stb_i on the same cycle as a window transfer.
   - All counters read 0 on the next cycle.
   - A following transfer gives windows_cnt_o=1.
6. Assert rst_n_i low asynchronously mid-packet, with valid_o=1 and ready_i=0.
   - valid_o=0 and counters 0 immediately, before any clock edge.
   - After release, a fresh 3-byte packet yields exactly one window.

Source files
------------

// File: rtl/str_window_former.sv
// Byte-stream to sliding-window former: emits every overlapping STR_SIZE-byte window
// of each packet on a valid/ready port, with saturating statistics counters.
module str_window_former #(
   parameter int BYTE_W   = 8,
   parameter int STR_SIZE = 3,
   parameter int CNT_W    = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_n_i,
   input  logic [BYTE_W-1:0]                data_i,
   input  logic                             sop_i,
   input  logic                             eop_i,
   input  logic                             valid_i,
   output logic                             ready_o,
   output logic [STR_SIZE-1:0][BYTE_W-1:0]  data_o,
   output logic                             valid_o,
   input  logic                             ready_i,
   output logic [CNT_W-1:0]                 windows_cnt_o,
   output logic [CNT_W-1:0]                 short_pkt_cnt_o,
   output logic [CNT_W-1:0]                 proto_err_cnt_o,
   input  logic                             cnt_clean_stb_i
);

   localparam int                FILL_W    = $clog2(STR_SIZE + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(STR_SIZE);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   // Reset asserts immediately but releases two clock edges after rst_n_i rises
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) rst_sync <= '0;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   logic [STR_SIZE-1:0][BYTE_W-1:0] shreg_p0, shreg_upd, win_p1;
   logic [FILL_W-1:0]               fill_p0, fill_upd;
   logic                            in_pkt_p0, vld_p1;
   logic                            accept, used, win_load, xfer;
   logic                            short_ev, proto_ev;
   logic [CNT_W-1:0]                win_cnt, short_cnt, proto_cnt;

   assign ready_o  = !vld_p1 || ready_i;
   assign accept   = valid_i && ready_o;
   assign used     = accept && (sop_i || in_pkt_p0);
   assign win_load = used && (fill_upd == FILL_FULL);
   assign xfer     = vld_p1 && ready_i;

   always_comb begin
      fill_upd = fill_p0;
      if (sop_i)                      fill_upd = FILL_W'(1);
      else if (fill_p0 != FILL_FULL) fill_upd = fill_p0 + FILL_W'(1);
      shreg_upd = shreg_p0;
      for (int i = 0; i < STR_SIZE - 1; i++) shreg_upd[i] = shreg_p0[i+1];
      shreg_upd[STR_SIZE-1] = data_i;
   end

   // A sop that aborts a short packet and a short packet ending here collapse into one event
   assign proto_ev = accept && ((sop_i && in_pkt_p0) || (!sop_i && !in_pkt_p0));
   assign short_ev = used && ((sop_i && in_pkt_p0 && (fill_p0 < FILL_FULL)) ||
                              (eop_i && (fill_upd < FILL_FULL)));

   // Stage p0: packet state and byte history
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         shreg_p0  <= '0;
         fill_p0   <= '0;
         in_pkt_p0 <= 1'b0;
      end else if (used) begin
         shreg_p0 <= shreg_upd;
         if (eop_i) begin
            fill_p0   <= '0;
            in_pkt_p0 <= 1'b0;
         end else begin
            fill_p0   <= fill_upd;
            in_pkt_p0 <= 1'b1;
         end
      end
   end

   // Stage p1: output window register, held while downstream stalls
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         win_p1 <= '0;
      end else if (win_load) begin
         vld_p1 <= 1'b1;
         win_p1 <= shreg_upd;
      end else if (ready_i) begin
         vld_p1 <= 1'b0;
      end
   end

   assign valid_o = vld_p1;
   assign data_o  = win_p1;

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt   <= '0;
         short_cnt <= '0;
         proto_cnt <= '0;
      end else if (cnt_clean_stb_i) begin
         win_cnt   <= '0;
         short_cnt <= '0;
         proto_cnt <= '0;
      end else begin
         if (xfer)     win_cnt   <= sat_inc(win_cnt);
         if (short_ev) short_cnt <= sat_inc(short_cnt);
         if (proto_ev) proto_cnt <= sat_inc(proto_cnt);
      end
   end

   assign windows_cnt_o   = win_cnt;
   assign short_pkt_cnt_o = short_cnt;
   assign proto_err_cnt_o = proto_cnt;

endmodule
